// File: rtl/sa2_tile_loader.sv
// sa2_tile_loader: stream-side front end of the 2x2 systolic array.
// Loads a 3x3 filter and a 4x4 data tile from a byte stream, holds the
// array enable until the array reports completion (or a watchdog expires),
// then streams the four results back out before accepting the next tile.
module sa2_tile_loader #(
  parameter int DW      = 8,   // stream byte / register / result width
  parameter int TIMEOUT = 64,  // max RUN cycles before giving up on done_sa2
  parameter int TCW     = 7    // RUN cycle counter width, must hold TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,

  // upstream byte stream
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,

  // data tile to the array, row-major
  output logic [DW-1:0] a11,
  output logic [DW-1:0] a12,
  output logic [DW-1:0] a13,
  output logic [DW-1:0] a14,
  output logic [DW-1:0] a21,
  output logic [DW-1:0] a22,
  output logic [DW-1:0] a23,
  output logic [DW-1:0] a24,
  output logic [DW-1:0] a31,
  output logic [DW-1:0] a32,
  output logic [DW-1:0] a33,
  output logic [DW-1:0] a34,
  output logic [DW-1:0] a41,
  output logic [DW-1:0] a42,
  output logic [DW-1:0] a43,
  output logic [DW-1:0] a44,

  // filter to the array, row-major
  output logic [DW-1:0] b11,
  output logic [DW-1:0] b12,
  output logic [DW-1:0] b13,
  output logic [DW-1:0] b21,
  output logic [DW-1:0] b22,
  output logic [DW-1:0] b23,
  output logic [DW-1:0] b31,
  output logic [DW-1:0] b32,
  output logic [DW-1:0] b33,

  // array control and results
  output logic          active_sa2,
  input  logic          done_sa2,
  input  logic [DW-1:0] c11,
  input  logic [DW-1:0] c12,
  input  logic [DW-1:0] c21,
  input  logic [DW-1:0] c22,

  // downstream result stream
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,

  // status
  output logic          busy,
  output logic          timeout_err
);

  typedef enum logic [1:0] {
    LOAD_F = 2'd0,  // filling filter registers
    LOAD_D = 2'd1,  // filling data-tile registers
    RUN    = 2'd2,  // array running, waiting for done_sa2
    DRAIN  = 2'd3   // streaming results out
  } state_t;

  localparam int F_LEN = 9;
  localparam int D_LEN = 16;
  localparam int R_LEN = 4;

  localparam logic [3:0]     F_LAST = 4'(F_LEN - 1);
  localparam logic [3:0]     D_LAST = 4'(D_LEN - 1);
  localparam logic [1:0]     O_LAST = 2'(R_LEN - 1);
  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT - 1);

  state_t         state;
  state_t         state_nxt;

  logic [3:0]     f_cnt;
  logic [3:0]     d_cnt;
  logic [TCW-1:0] t_cnt;
  logic [1:0]     o_cnt;

  logic [DW-1:0]  filt [F_LEN];
  logic [DW-1:0]  tile [D_LEN];
  logic [DW-1:0]  res  [R_LEN];

  logic           load_st;
  logic           in_fire;
  logic           out_fire;
  logic           f_last;
  logic           d_last;
  logic           o_last;
  logic           t_last;

  // Handshake qualifiers. in_ready is kept low during reset so no byte is
  // taken while the loader is being cleared.
  assign load_st  = (state == LOAD_F) || (state == LOAD_D);
  assign in_ready = load_st && !rst;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  assign f_last = (f_cnt == F_LAST);
  assign d_last = (d_cnt == D_LAST);
  assign o_last = (o_cnt == O_LAST);
  assign t_last = (t_cnt == T_LAST);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      state <= LOAD_F;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and state-derived control outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // skipped an assignment would otherwise infer a latch.
    state_nxt  = state;
    active_sa2 = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state)
      LOAD_F: begin
        if (in_fire && f_last) state_nxt = LOAD_D;
      end
      LOAD_D: begin
        if (in_fire && d_last) state_nxt = RUN;
      end
      RUN: begin
        active_sa2 = 1'b1;
        busy       = 1'b1;
        // done_sa2 takes priority over the watchdog in the same cycle.
        if (done_sa2 || t_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_fire && o_last) state_nxt = LOAD_F;
      end
      default: state_nxt = LOAD_F;
    endcase
  end

  // Counters, filter/tile/result registers and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_cnt       <= '0;
      d_cnt       <= '0;
      t_cnt       <= '0;
      o_cnt       <= '0;
      timeout_err <= 1'b0;
      // NOTE: these register arrays are cleared on reset because the array
      // sees them directly and a mid-load reset must not leave a partial tile.
      for (int i = 0; i < F_LEN; i++) filt[i] <= '0;
      for (int i = 0; i < D_LEN; i++) tile[i] <= '0;
      for (int i = 0; i < R_LEN; i++) res[i]  <= '0;
    end else begin
      unique case (state)
        LOAD_F: begin
          if (in_fire) begin
            filt[f_cnt] <= in_data;
            f_cnt       <= f_last ? 4'd0 : f_cnt + 4'd1;
          end
        end
        LOAD_D: begin
          if (in_fire) begin
            tile[d_cnt] <= in_data;
            d_cnt       <= d_last ? 4'd0 : d_cnt + 4'd1;
            if (d_last) t_cnt <= '0;
          end
        end
        RUN: begin
          t_cnt <= t_cnt + TCW'(1);
          if (done_sa2) begin
            res[0] <= c11;
            res[1] <= c12;
            res[2] <= c21;
            res[3] <= c22;
          end else if (t_last) begin
            for (int i = 0; i < R_LEN; i++) res[i] <= '0;
            timeout_err <= 1'b1;
          end
        end
        DRAIN: begin
          if (out_fire) o_cnt <= o_last ? 2'd0 : o_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Results leave straight from registers; no path from in_* to out_*.
  assign out_data = res[o_cnt];

  assign b11 = filt[0];
  assign b12 = filt[1];
  assign b13 = filt[2];
  assign b21 = filt[3];
  assign b22 = filt[4];
  assign b23 = filt[5];
  assign b31 = filt[6];
  assign b32 = filt[7];
  assign b33 = filt[8];

  assign a11 = tile[0];
  assign a12 = tile[1];
  assign a13 = tile[2];
  assign a14 = tile[3];
  assign a21 = tile[4];
  assign a22 = tile[5];
  assign a23 = tile[6];
  assign a24 = tile[7];
  assign a31 = tile[8];
  assign a32 = tile[9];
  assign a33 = tile[10];
  assign a34 = tile[11];
  assign a41 = tile[12];
  assign a42 = tile[13];
  assign a43 = tile[14];
  assign a44 = tile[15];

endmodule

// File: tb/tb_sa2_tile_loader.sv
// tb_sa2_tile_loader: self-checking bench for sa2_tile_loader.
// A stub array answers done_sa2 after a chosen number of RUN cycles; the
// expected registers, result bytes and error flag come from a simple model
// of what was streamed in and how the array answered.
module tb_sa2_tile_loader;

  localparam int DW      = 8;
  localparam int TIMEOUT = 64;
  localparam int TCW     = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [DW-1:0] a11, a12, a13, a14, a21, a22, a23, a24;
  logic [DW-1:0] a31, a32, a33, a34, a41, a42, a43, a44;
  logic [DW-1:0] b11, b12, b13, b21, b22, b23, b31, b32, b33;
  logic          active_sa2;
  logic          done_sa2;
  logic [DW-1:0] c11, c12, c21, c22;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          busy;
  logic          timeout_err;

  int errors = 0;
  int checks = 0;

  // model state
  logic [7:0] exp_f [9];
  logic [7:0] exp_t [16];
  logic       exp_terr;

  sa2_tile_loader #(.DW(DW), .TIMEOUT(TIMEOUT), .TCW(TCW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .a11(a11), .a12(a12), .a13(a13), .a14(a14),
    .a21(a21), .a22(a22), .a23(a23), .a24(a24),
    .a31(a31), .a32(a32), .a33(a33), .a34(a34),
    .a41(a41), .a42(a42), .a43(a43), .a44(a44),
    .b11(b11), .b12(b12), .b13(b13),
    .b21(b21), .b22(b22), .b23(b23),
    .b31(b31), .b32(b32), .b33(b33),
    .active_sa2(active_sa2), .done_sa2(done_sa2),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  logic [199:0] obs_regs;
  assign obs_regs = {b11, b12, b13, b21, b22, b23, b31, b32, b33,
                     a11, a12, a13, a14, a21, a22, a23, a24,
                     a31, a32, a33, a34, a41, a42, a43, a44};

  function automatic logic [199:0] exp_regs();
    logic [199:0] r = '0;
    for (int i = 0; i < 9; i++)  r = {r[191:0], exp_f[i]};
    for (int i = 0; i < 16; i++) r = {r[191:0], exp_t[i]};
    return r;
  endfunction

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    int bad = 0;
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    done_sa2 = 1'b0; out_ready = 1'b0;
    #1;
    for (int i = 0; i < cycles; i++) begin
      if (in_ready !== 1'b0) bad++;
      tick();
      if (in_ready !== 1'b0 || active_sa2 !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_hold: %0d bad cycles, required 0", bad);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    for (int i = 0; i < 9; i++)  exp_f[i] = '0;
    for (int i = 0; i < 16; i++) exp_t[i] = '0;
    exp_terr = 1'b0;
    checks++;
    if ({in_ready, busy, timeout_err, out_valid, active_sa2, out_data} !== {5'b10000, 8'h00}) begin
      errors++;
      $display("FAIL reset_release: rdy/busy/terr/ov/act/od=%b%b%b%b%b/%h required 10000/00",
               in_ready, busy, timeout_err, out_valid, active_sa2, out_data);
    end
    checks++;
    if (obs_regs !== exp_regs()) begin
      errors++;
      $display("FAIL reset_regs: got %h required %h", obs_regs, exp_regs());
    end
  endtask

  // mode 0: in_valid always 1; 1: alternate 1/0; 2: random gaps.
  // Only a complete 25-beat load updates the model.
  task automatic load_tile(input logic [7:0] bytes[25], input int mode, input int n_beats,
                           output int cycles);
    int  i = 0;
    int  bad = 0;
    bit  go;
    bit  fire;
    cycles = 0;
    while (i < n_beats && cycles < 400) begin
      case (mode)
        0:       go = 1'b1;
        1:       go = (cycles % 2 == 0);
        default: go = ($urandom_range(99) >= 40);
      endcase
      in_valid  = go;
      in_data   = go ? bytes[i] : 8'($urandom);
      done_sa2  = 1'($urandom);   // must be ignored outside RUN
      c11 = 8'($urandom); c12 = 8'($urandom); c21 = 8'($urandom); c22 = 8'($urandom);
      out_ready = 1'($urandom);   // must be ignored outside DRAIN
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || active_sa2 !== 1'b0) bad++;
      fire = go && (in_ready === 1'b1);
      tick();
      cycles++;
      if (fire) i++;
    end
    in_valid = 1'b0; done_sa2 = 1'b0; out_ready = 1'b0;
    checks++;
    if (i != n_beats || bad != 0) begin
      errors++;
      $display("FAIL load: beats=%0d bad_cycles=%0d required beats=%0d bad_cycles=0", i, bad, n_beats);
    end
    if (n_beats == 25) begin
      for (int k = 0; k < 9; k++)  exp_f[k] = bytes[k];
      for (int k = 0; k < 16; k++) exp_t[k] = bytes[9 + k];
      checks++;
      if (active_sa2 !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL run_entry: act/busy/rdy=%b%b%b required 110", active_sa2, busy, in_ready);
      end
      checks++;
      if (obs_regs !== exp_regs()) begin
        errors++;
        $display("FAIL load_regs: got %h required %h", obs_regs, exp_regs());
      end
    end
  endtask

  // Array stub: pulses done_sa2 on RUN cycle done_at (1-based) with values cv.
  task automatic run_phase(input int done_at, input logic [7:0] cv[4], output logic [7:0] exp_out[4]);
    int n   = (done_at <= TIMEOUT) ? done_at : TIMEOUT;
    int bad = 0;
    for (int k = 1; k <= n; k++) begin
      if (active_sa2 !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      done_sa2 = (k == done_at);
      c11 = (k == done_at) ? cv[0] : 8'($urandom);
      c12 = (k == done_at) ? cv[1] : 8'($urandom);
      c21 = (k == done_at) ? cv[2] : 8'($urandom);
      c22 = (k == done_at) ? cv[3] : 8'($urandom);
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      out_ready = 1'($urandom);
      tick();
    end
    done_sa2 = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    if (done_at <= TIMEOUT) begin
      exp_out = cv;
    end else begin
      exp_out  = '{8'h00, 8'h00, 8'h00, 8'h00};
      exp_terr = 1'b1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL run_hold: %0d bad RUN cycles of %0d, required 0", bad, n);
    end
    checks++;
    if (active_sa2 !== 1'b0 || out_valid !== 1'b1 || timeout_err !== exp_terr) begin
      errors++;
      $display("FAIL drain_entry: act/ov/terr=%b%b%b required 01%b",
               active_sa2, out_valid, timeout_err, exp_terr);
    end
    checks++;
    if (obs_regs !== exp_regs()) begin
      errors++;
      $display("FAIL run_regs_stable: got %h required %h", obs_regs, exp_regs());
    end
  endtask

  // Takes n_take result beats; out_ready drops for 3 cycles at beat stall_at.
  task automatic drain(input logic [7:0] exp_out[4], input int stall_at, input bit rand_ready,
                       input int n_take);
    int i = 0, cycles = 0, stall = 0;
    bit acc;
    while (i < n_take && cycles < 200) begin
      if (i == stall_at && stall < 3) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = rand_ready ? 1'($urandom) : 1'b1;
      end
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_out[i] || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL drain_beat%0d: ov/od/rdy=%b/%h/%b required 1/%h/0",
                 i, out_valid, out_data, in_ready, exp_out[i]);
      end
      acc = out_ready;
      tick();
      cycles++;
      if (acc) i++;
    end
    out_ready = 1'b0; in_valid = 1'b0;
    checks++;
    if (i != n_take) begin
      errors++;
      $display("FAIL drain_count: %0d beats required %0d", i, n_take);
    end
    if (n_take == 4) begin
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || timeout_err !== exp_terr) begin
        errors++;
        $display("FAIL drain_exit: rdy/ov/busy/terr=%b%b%b%b required 100%b",
                 in_ready, out_valid, busy, timeout_err, exp_terr);
      end
      checks++;
      if (obs_regs !== exp_regs()) begin
        errors++;
        $display("FAIL regs_hold: got %h required %h", obs_regs, exp_regs());
      end
    end
  endtask

  function automatic void seq_bytes(output logic [7:0] b[25]);
    for (int i = 0; i < 9; i++)  b[i]     = 8'(1 + i);
    for (int i = 0; i < 16; i++) b[9 + i] = 8'(8'h10 + i);
  endfunction

  logic [7:0] t3_c [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  task automatic test_reset();
    do_reset(3);
  endtask

  task automatic test_load_run_drain();
    logic [7:0] b [25];
    logic [7:0] eo [4];
    int cyc;
    seq_bytes(b);
    load_tile(b, 0, 25, cyc);
    checks++;
    if (cyc != 25 || b11 !== 8'h01 || b33 !== 8'h09 || a11 !== 8'h10 || a44 !== 8'h1F) begin
      errors++;
      $display("FAIL t2_load: cycles=%0d b11=%h b33=%h a11=%h a44=%h required 25 01 09 10 1f",
               cyc, b11, b33, a11, a44);
    end
    run_phase(5, t3_c, eo);
    drain(eo, -1, 1'b0, 4);
  endtask

  task automatic test_backpressure();
    logic [7:0] b [25];
    logic [7:0] eo [4];
    int cyc;
    seq_bytes(b);
    load_tile(b, 1, 25, cyc);
    run_phase(5, t3_c, eo);
    drain(eo, 1, 1'b0, 4);
  endtask

  task automatic test_timeout();
    logic [7:0] b [25];
    logic [7:0] eo [4];
    logic [7:0] cv [4];
    int cyc;
    for (int i = 0; i < 25; i++) b[i] = 8'($urandom);
    load_tile(b, 0, 25, cyc);
    run_phase(TIMEOUT + 10, t3_c, eo);
    drain(eo, -1, 1'b0, 4);
    // good tile afterwards: error flag stays set
    for (int i = 0; i < 25; i++) b[i] = 8'($urandom);
    load_tile(b, 2, 25, cyc);
    run_phase(3, t3_c, eo);
    drain(eo, -1, 1'b1, 4);
    // done in the timeout cycle wins
    do_reset(1);
    for (int i = 0; i < 4; i++) cv[i] = 8'($urandom);
    load_tile(b, 0, 25, cyc);
    run_phase(TIMEOUT, cv, eo);
    drain(eo, -1, 1'b0, 4);
  endtask

  task automatic test_mid_reset();
    logic [7:0] b [25];
    logic [7:0] eo [4];
    int cyc;
    seq_bytes(b);
    load_tile(b, 0, 12, cyc);
    do_reset(2);
    load_tile(b, 0, 25, cyc);
    run_phase(5, t3_c, eo);
    drain(eo, -1, 1'b0, 2);
    do_reset(2);
    load_tile(b, 0, 25, cyc);
    run_phase(5, t3_c, eo);
    drain(eo, -1, 1'b0, 4);
  endtask

  task automatic test_random();
    logic [7:0] b [25];
    logic [7:0] eo [4];
    logic [7:0] cv [4];
    int cyc;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 25; i++) b[i] = 8'($urandom);
      for (int i = 0; i < 4; i++)  cv[i] = 8'($urandom);
      load_tile(b, 2, 25, cyc);
      run_phase(int'($urandom_range(TIMEOUT + 4, 1)), cv, eo);
      drain(eo, int'($urandom_range(4)) - 1, 1'b1, 4);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; done_sa2 = 1'b0;
    c11 = '0; c12 = '0; c21 = '0; c22 = '0; out_ready = 1'b0;
    exp_terr = 1'b0;
    test_reset();
    test_load_run_drain();
    test_backpressure();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
